// File: rtl/ppfifo_ingress_writer.sv
// Ingress writer for a ping-pong FIFO: claims a free buffer, streams upstream
// words into it with one cycle of latency, and releases it on last, full or idle timeout.
//
//   state   | meaning
//   IDLE    | no buffer owned, waiting for a ready flag
//   WRITE   | buffer owned, accepting upstream words
//   RELEASE | final cycle of ownership, act drops at the next edge
module ppfifo_ingress_writer #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  input  logic        i_last,
  output logic        o_ready,
  input  logic [1:0]  i_ingress_rdy,
  output logic [1:0]  o_ingress_act,
  output logic        o_ingress_stb,
  output logic [31:0] o_ingress_data,
  input  logic [23:0] i_ingress_size,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, WRITE, RELEASE} state_t;

  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  act_q, act_d;
  logic        stb_q, stb_d;
  logic [31:0] data_q, data_d;
  logic [23:0] count_q, count_d;
  logic [15:0] idle_q, idle_d;

  logic        timeout_hit;
  logic        accept;
  logic [23:0] count_inc;

  // An empty buffer never times out; a partial one is flushed after TIMEOUT quiet cycles.
  assign timeout_hit = (count_q != 24'd0) && (idle_q == IDLE_LIMIT);
  assign o_ready     = (state_q == WRITE) && (count_q < i_ingress_size) && !timeout_hit;
  assign accept      = i_valid && o_ready;
  assign count_inc   = count_q + 24'd1;

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    stb_d   = 1'b0;
    data_d  = data_q;
    count_d = count_q;
    idle_d  = idle_q;
    case (state_q)
      IDLE: begin
        idle_d = 16'd0;
        if (act_q == 2'b00 && i_ingress_rdy != 2'b00) begin
          act_d   = i_ingress_rdy[0] ? 2'b01 : 2'b10;
          count_d = 24'd0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          stb_d   = 1'b1;
          data_d  = i_data;
          count_d = count_inc;
          idle_d  = 16'd0;
          if (i_last || count_inc == i_ingress_size) begin
            state_d = RELEASE;
          end
        end else begin
          idle_d = idle_q + 16'd1;
          if (i_ingress_size == 24'd0 || timeout_hit) begin
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        // act stays high through this cycle so the last strobe lands inside ownership
        act_d   = 2'b00;
        idle_d  = 16'd0;
        state_d = IDLE;
      end
      default: begin
        act_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      act_q   <= 2'b00;
      stb_q   <= 1'b0;
      data_q  <= 32'd0;
      count_q <= 24'd0;
      idle_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
      count_q <= count_d;
      idle_q  <= idle_d;
    end
  end

  assign o_ingress_act  = act_q;
  assign o_ingress_stb  = stb_q;
  assign o_ingress_data = data_q;
  assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ppfifo_ingress_writer.sv
// Bench for ppfifo_ingress_writer: scenario table, multi-cycle corner sequences,
// then random traffic against a cycle-level ownership/fill model.
module tb_ppfifo_ingress_writer;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_data = 32'd0;
  logic        i_last = 1'b0;
  logic        o_ready;
  logic [1:0]  i_ingress_rdy = 2'b00;
  logic [1:0]  o_ingress_act;
  logic        o_ingress_stb;
  logic [31:0] o_ingress_data;
  logic [23:0] i_ingress_size = 24'd0;
  logic        o_busy;

  ppfifo_ingress_writer #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
    .o_ready(o_ready), .i_ingress_rdy(i_ingress_rdy), .o_ingress_act(o_ingress_act),
    .o_ingress_stb(o_ingress_stb), .o_ingress_data(o_ingress_data),
    .i_ingress_size(i_ingress_size), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  act;
    logic [31:0] data;
  } stb_t;
  stb_t mon_q[$];
  int   ready_hi = 0;

  always @(negedge clk) begin
    if (o_ready) ready_hi++;
    if (o_ingress_stb) begin
      mon_q.push_back('{o_ingress_act, o_ingress_data});
      check("stb_inside_act", {31'd0, o_ingress_act != 2'b00}, 32'd1);
    end
  end

  logic       auto_rdy = 1'b0;
  logic [1:0] want = 2'b01;

  task automatic rdy_ctl();
    if (auto_rdy) begin
      if (o_ingress_act == 2'b00) i_ingress_rdy = want;
      else if (i_ingress_rdy != 2'b00) begin
        i_ingress_rdy = 2'b00;
        want = ~want;
      end
    end
  endtask

  // Called at a negedge; returns at the following negedge with i_valid low.
  task automatic send_beat(input logic [31:0] d, input logic l, output time t_acc);
    int w = 0;
    i_valid = 1'b1; i_data = d; i_last = l;
    #1;
    while (!o_ready && w < 60) begin
      @(negedge clk);
      rdy_ctl();
      #1;
      w++;
    end
    check("ready_wait", {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic wait_fall(input time evt, input int exp_lat, input string nm);
    int n = 0;
    int lat;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (o_ingress_act != 2'b00 && n < 200);
    lat = int'(($time - 1 - evt) / 10);
    check({nm, "_release_lat"}, lat, exp_lat);
  endtask

  typedef struct {
    logic [1:0]  rdy;
    logic [23:0] size;
    int          nbeats;
    int          last_at;
    logic [1:0]  exp_act;
    int          exp_lat;
    string       name;
  } scn_t;

  scn_t tbl[7];

  // cycle-level reference state for the random phase
  logic [1:0]  m_act;
  int          m_fill, m_since;
  logic        m_closing;

  initial begin
    time t_evt, t_acc;
    int  rh0;
    logic [31:0] base;

    tbl[0] = '{2'b11, 24'd4,  4, 0, 2'b01, 1,       "full4"};
    tbl[1] = '{2'b10, 24'd16, 3, 3, 2'b10, 1,       "last3"};
    tbl[2] = '{2'b01, 24'd16, 2, 0, 2'b01, TMO + 1, "timeout2"};
    tbl[3] = '{2'b01, 24'd0,  0, 0, 2'b01, 2,       "size0"};
    tbl[4] = '{2'b10, 24'd1,  1, 0, 2'b10, 1,       "size1"};
    tbl[5] = '{2'b11, 24'd3,  3, 3, 2'b01, 1,       "last_full"};
    tbl[6] = '{2'b01, 24'd5,  1, 1, 2'b01, 1,       "single_last"};

    // reset behaviour
    i_ingress_rdy = 2'b01; i_ingress_size = 24'd4;
    #3;
    check("rst_act", {30'd0, o_ingress_act}, 32'd0);
    check("rst_stb", {31'd0, o_ingress_stb}, 32'd0);
    check("rst_data", o_ingress_data, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_acq", {30'd0, o_ingress_act}, 32'd0);
    @(negedge clk);
    i_ingress_rdy = 2'b00;
    rst = 1'b1;
    @(negedge clk);

    // scenario table
    for (int i = 0; i < 7; i++) begin
      base = 32'hA0 + 32'(i) * 32'h10;
      mon_q.delete();
      rh0 = ready_hi;
      i_ingress_size = tbl[i].size;
      i_ingress_rdy  = tbl[i].rdy;
      @(posedge clk);
      t_evt = $time;
      #1;
      check({tbl[i].name, "_acq"}, {30'd0, o_ingress_act}, {30'd0, tbl[i].exp_act});
      @(negedge clk);
      i_ingress_rdy = 2'b00;
      for (int k = 0; k < tbl[i].nbeats; k++) begin
        send_beat(base + 32'(k), (k + 1) == tbl[i].last_at, t_acc);
        t_evt = t_acc;
      end
      wait_fall(t_evt, tbl[i].exp_lat, tbl[i].name);
      @(negedge clk);
      check({tbl[i].name, "_busy_low"}, {31'd0, o_busy}, 32'd0);
      repeat (3) @(negedge clk);
      check({tbl[i].name, "_nstb"}, mon_q.size(), tbl[i].nbeats);
      for (int k = 0; k < mon_q.size() && k < tbl[i].nbeats; k++) begin
        check({tbl[i].name, "_data"}, mon_q[k].data, base + 32'(k));
        check({tbl[i].name, "_owner"}, {30'd0, mon_q[k].act}, {30'd0, tbl[i].exp_act});
      end
      if (tbl[i].size == 24'd0) check("size0_ready_never", ready_hi - rh0, 0);
    end

    // alternating buffers, size 2, five back-to-back beats
    mon_q.delete();
    i_ingress_size = 24'd2;
    want = 2'b01; auto_rdy = 1'b1; i_ingress_rdy = 2'b01;
    for (int k = 0; k < 5; k++) send_beat(32'hB0 + 32'(k), 1'b0, t_acc);
    auto_rdy = 1'b0; i_ingress_rdy = 2'b00;
    wait_fall(t_acc, TMO + 1, "alt_last");
    repeat (3) @(negedge clk);
    check("alt_nstb", mon_q.size(), 5);
    begin
      logic [1:0] own_exp [5];
      own_exp = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
      for (int k = 0; k < mon_q.size() && k < 5; k++) begin
        check("alt_owner", {30'd0, mon_q[k].act}, {30'd0, own_exp[k]});
        check("alt_data", mon_q[k].data, 32'hB0 + 32'(k));
      end
    end

    // empty buffer is held without timeout
    i_ingress_size = 24'd16; i_ingress_rdy = 2'b01;
    @(posedge clk);
    #1;
    check("hold_acq", {30'd0, o_ingress_act}, 32'd1);
    @(negedge clk);
    i_ingress_rdy = 2'b00;
    begin
      int held = 0;
      for (int k = 0; k < 100; k++) begin
        @(posedge clk);
        #1;
        if (o_ingress_act == 2'b01) held++;
      end
      check("hold_no_timeout", held, 100);
    end
    @(negedge clk);
    send_beat(32'hC0, 1'b1, t_acc);
    wait_fall(t_acc, 1, "hold_end");
    @(negedge clk);

    // asynchronous reset in the middle of a buffer
    mon_q.delete();
    i_ingress_size = 24'd16; i_ingress_rdy = 2'b01;
    @(posedge clk);
    @(negedge clk);
    i_ingress_rdy = 2'b00;
    send_beat(32'hD0, 1'b0, t_acc);
    send_beat(32'hD1, 1'b0, t_acc);
    i_valid = 1'b1; i_data = 32'hD2;
    @(posedge clk);
    #1;
    check("pre_rst_stb", {31'd0, o_ingress_stb}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("arst_act", {30'd0, o_ingress_act}, 32'd0);
    check("arst_stb", {31'd0, o_ingress_stb}, 32'd0);
    check("arst_ready", {31'd0, o_ready}, 32'd0);
    check("arst_busy", {31'd0, o_busy}, 32'd0);
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mon_q.delete();
    i_ingress_size = 24'd2; i_ingress_rdy = 2'b01;
    @(posedge clk);
    #1;
    check("post_rst_acq", {30'd0, o_ingress_act}, 32'd1);
    @(negedge clk);
    i_ingress_rdy = 2'b00;
    send_beat(32'hE0, 1'b0, t_acc);
    send_beat(32'hE1, 1'b0, t_acc);
    wait_fall(t_acc, 1, "post_rst_count");
    repeat (2) @(negedge clk);
    check("post_rst_nstb", mon_q.size(), 2);

    // random traffic against the reference model
    m_act = 2'b00; m_fill = 0; m_since = 0; m_closing = 1'b0;
    begin
      int vprob = 7;
      for (int c = 0; c < 3000; c++) begin
        logic exp_ready, acc, fall, l_now;
        logic [31:0] d_now;
        int r;
        @(negedge clk);
        if (c % 50 == 0) vprob = $urandom_range(0, 2) == 0 ? 1 : $urandom_range(5, 10);
        if (m_act == 2'b00) begin
          r = $urandom_range(0, 15);
          i_ingress_size = (r == 0) ? 24'd0 : 24'(1 + r % 5);
        end
        i_ingress_rdy = 2'($urandom_range(0, 3));
        i_valid = ($urandom_range(0, 9) < vprob);
        i_data  = $urandom;
        i_last  = ($urandom_range(0, 5) == 0);
        #1;
        exp_ready = (m_act != 2'b00) && !m_closing && (i_ingress_size != 24'd0) &&
                    (m_fill < int'(i_ingress_size)) && !(m_fill > 0 && m_since >= TMO - 1);
        check("rnd_ready", {31'd0, o_ready}, {31'd0, exp_ready});
        acc = i_valid && exp_ready;
        l_now = i_last; d_now = i_data;
        @(posedge clk);
        #1;
        if (m_act == 2'b00) begin
          m_act = (i_ingress_rdy == 2'b00) ? 2'b00 : (i_ingress_rdy[0] ? 2'b01 : 2'b10);
          m_fill = 0; m_since = 0; m_closing = 1'b0;
          check("rnd_stb", {31'd0, o_ingress_stb}, 32'd0);
        end else begin
          if (acc) begin
            m_fill++;
            m_since = 0;
            m_closing = l_now || (m_fill == int'(i_ingress_size));
          end else m_since++;
          fall = (m_closing && m_since == 1) ||
                 (!m_closing && m_fill > 0 && m_since == TMO + 1) ||
                 (i_ingress_size == 24'd0 && m_since == 2);
          if (fall) m_act = 2'b00;
          check("rnd_stb", {31'd0, o_ingress_stb}, {31'd0, acc});
          if (acc) check("rnd_data", o_ingress_data, d_now);
        end
        check("rnd_act", {30'd0, o_ingress_act}, {30'd0, m_act});
        check("rnd_busy", {31'd0, o_busy}, {31'd0, m_act != 2'b00});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
